vga_frame_timer: RTL and testbench
==================================

# vga_frame_timer

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Produces the pixel coordinates (DrawX, DrawY) consumed by the colour mapper and sprite logic, plus the VGA pixel clock, sync and blank outputs. Sync and blank are delayed by a parameterised number of pixel ticks so they stay aligned with the registered RGB pipeline downstream of the colour mapper.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIPE_DEPTH, 2, sync/blank delay in pixel ticks; legal range 1..4

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous active-low reset
- run  in  1  when low, the counters hold and the pixel-tick divider keeps running
- VGA_CLK  out  1  25 MHz pixel clock; equals pix_phase
- DrawX  out  10  current horizontal count; 0..H_TOTAL-1
- DrawY  out  10  current vertical count; 0..V_TOTAL-1
- VGA_HS  out  1  horizontal sync, active low, delayed
- VGA_VS  out  1  vertical sync, active low, delayed
- VGA_BLANK_N  out  1  high in the visible region, delayed
- line_start  out  1  one-Clk pulse when DrawX wraps to 0
- frame_start  out  1  one-Clk pulse when DrawX and DrawY both wrap to 0
- frame_count  out  16  frame counter; present only with VGA_FRAME_COUNT_EN

## Operation
- Totals: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- pix_phase: a 1-bit register that toggles every Clk.
- Pixel tick: the Clk edge on which pix_phase == 1. All counter and pipeline updates occur only on pixel ticks.
- On a pixel tick with run = 1:
  - h_cnt increments. If h_cnt == H_TOTAL-1, h_cnt wraps to 0.
  - On that wrap, v_cnt increments. If v_cnt == V_TOTAL-1, v_cnt wraps to 0.
- DrawX and DrawY are h_cnt and v_cnt directly. They are not delayed.
- Decode from the counters:
  - hs_raw = 0 when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - blank_raw_n = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Delay pipeline: a PIPE_DEPTH-stage shift register carries {hs, vs, blank_n}. It advances only on pixel ticks with run = 1. When run = 0, the pipeline holds.
- Pulses:
  - line_start is a registered output. It is high for exactly one Clk after the tick that wraps h_cnt to 0.
  - frame_start is also a registered output. It is high for exactly one Clk after the tick that wraps both counters to 0.
  - Reset does not generate either pulse.
- Counter widths: 10-bit counters; all comparisons are unsigned.

## Timing
- Reset values (asynchronous, while Reset_n = 0):
  - pix_phase = 0, so VGA_CLK = 0.
  - h_cnt = 0 and v_cnt = 0, so DrawX = 0 and DrawY = 0.
  - All pipeline stages = {1, 1, 0}, so VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
  - line_start = 0, frame_start = 0, frame_count = 0.
- After Reset_n rises: the first pixel tick is the 2nd Clk edge; DrawX becomes 1 there.
- Counters advance every 2 Clk. One line = 1600 Clk. One frame = 840000 Clk.
- Sync/blank latency: VGA_HS, VGA_VS and VGA_BLANK_N reflect the counter value from PIPE_DEPTH pixel ticks earlier (2*PIPE_DEPTH Clk).
- Mid-operation reset: all state returns to reset values immediately. In-flight pipeline contents are discarded.
- run deasserted at the wrap tick: the wrap does not occur and no pulse is issued. The wrap happens on the first pixel tick after run returns high.

## Configuration
- VGA_FRAME_COUNT_EN:
  - When defined: a 16-bit frame_count port and register exist. frame_count increments, wrapping at 0xFFFF→0, in the same Clk that frame_start asserts.
  - When undefined: the port and register are absent. All other behaviour is identical.

## Test plan
- Reset/cadence: hold Reset_n low 5 Clk, then release.
  - Outputs hold reset values while Reset_n is low.
  - VGA_CLK toggles every Clk.
  - DrawX reads 1, 2, 3 on the 2nd, 4th and 6th Clk edges.
- Horizontal sync with PIPE_DEPTH=2:
  - VGA_HS falls 2 ticks after DrawX = 656 and rises 2 ticks after DrawX = 752. Low width = 96 ticks.
  - VGA_BLANK_N falls 2 ticks after DrawX = 640.
- Line/frame wrap:
  - At DrawX = 799, the next tick gives DrawX = 0 and DrawY + 1, with one line_start pulse.
  - At (799, 524), the next tick gives (0, 0), with one line_start pulse and one frame_start pulse.
  - frame_start is separated by 840000 Clk.
- Vertical sync: VGA_VS is low for exactly 2 lines (3200 Clk), beginning 2 ticks after DrawY = 490, DrawX = 0.
- run stall: drop run at DrawX = 100 for 10 Clk.
  - DrawX, VGA_HS and VGA_BLANK_N all hold.
  - VGA_CLK keeps toggling.
  - On resume, DrawX continues at 101.
- Reset mid-frame and frame count:
  - Assert Reset_n low at (300, 200): all outputs return to reset values asynchronously.
  - With VGA_FRAME_COUNT_EN: frame_count reads 3 after 3 frame_start pulses and returns to 0 on reset.

Source files
------------

// File: rtl/vga_frame_timer.sv
// vga_frame_timer: 640x480@60 Hz raster timing from the 50 MHz system clock.
// A 1-bit phase register divides Clk by two; every Clk edge on which the phase
// is high is a pixel tick. The horizontal and vertical counters advance only on
// pixel ticks while run is high. DrawX/DrawY expose the counters directly.
// Sync and blank are delayed PIPE_DEPTH ticks so they line up with the
// registered RGB path behind the colour mapper.
//
// Optional feature: define VGA_FRAME_COUNT_EN to add a 16-bit frame_count
// port that increments in the same Clk as frame_start.
//
// PIPE_DEPTH legal range is 1..4.

module vga_frame_timer #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        run,
    output logic        VGA_CLK,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Pipeline word layout: {hs_n, vs_n, blank_n}; idle value keeps syncs
    // inactive and the display blanked.
    localparam logic [2:0] PIPE_IDLE  = 3'b110;

    logic       pix_phase;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       advance;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_raw;
    logic       vs_raw;
    logic       blank_raw_n;
    logic [2:0] pipe [PIPE_DEPTH];

    assign advance     = pix_phase & run;
    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);

    assign hs_raw      = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_raw      = ~((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign blank_raw_n = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    assign VGA_CLK     = pix_phase;
    assign DrawX       = h_cnt;
    assign DrawY       = v_cnt;
    assign VGA_HS      = pipe[PIPE_DEPTH-1][2];
    assign VGA_VS      = pipe[PIPE_DEPTH-1][1];
    assign VGA_BLANK_N = pipe[PIPE_DEPTH-1][0];

    // Divide Clk by two; the divider ignores run so VGA_CLK never stops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_phase <= 1'b0;
        end else begin
            pix_phase <= ~pix_phase;
        end
    end

    // Raster counters: horizontal wraps at H_LAST and carries into vertical.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (advance) begin
            if (h_wrap) begin
                h_cnt <= '0;
                if (v_wrap) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Line/frame pulses are recomputed every Clk, so each lasts exactly one Clk.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= advance & h_wrap;
            frame_start <= advance & h_wrap & v_wrap;
        end
    end

    // Sync/blank delay line; it freezes with the counters when run is low.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                pipe[i] <= PIPE_IDLE;
            end
        end else if (advance) begin
            pipe[0] <= {hs_raw, vs_raw, blank_raw_n};
            for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Frame counter steps on the same edge that raises frame_start.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count <= '0;
        end else if (advance && h_wrap && v_wrap) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer with a reduced raster so several frames fit in a
// short run. The reference model tracks only "Clk edges since reset" and
// "pixel ticks taken since reset"; every output is derived from those two
// numbers with division/modulo. Expected outputs are queued at each posedge
// and compared by a separate monitor at the following negedge.
`timescale 1ns/1ps

module tb_vga_frame_timer;

    localparam int HV = 40, HF = 6, HS = 8, HB = 6;
    localparam int VV = 12, VF = 3, VS = 2, VB = 4;
    localparam int PD = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        run = 1'b1;
    logic        VGA_CLK;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        line_start;
    logic        frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ck;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];

    vga_frame_timer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PIPE_DEPTH(PD)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .run(run),
        .VGA_CLK(VGA_CLK),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N),
        .line_start(line_start),
        .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    initial forever #10 Clk = ~Clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs after e Clk edges since reset, n pixel ticks taken, tk = this edge was a taken tick.
    function automatic exp_t expect_at(int e, int n, bit tk);
        exp_t r;
        int m;
        int hm;
        int vm;
        r.ck = (e % 2 == 1);
        r.x  = 10'(n % HT);
        r.y  = 10'((n / HT) % VT);
        if (n >= PD) begin
            m  = n - PD;
            hm = m % HT;
            vm = (m / HT) % VT;
            r.hs = !(hm >= HV + HF && hm < HV + HF + HS);
            r.vs = !(vm >= VV + VF && vm < VV + VF + VS);
            r.bn = (hm < HV) && (vm < VV);
        end else begin
            r.hs = 1'b1;
            r.vs = 1'b1;
            r.bn = 1'b0;
        end
        r.ls = tk && (n % HT == 0);
        r.fs = tk && (n % FT == 0);
        r.fc = 16'(n / FT);
        return r;
    endfunction

    // Reference model: count edges and taken ticks, queue the expected outputs.
    initial begin
        int e;
        int n;
        bit tk;
        e = 0;
        n = 0;
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) begin
                e  = 0;
                n  = 0;
                tk = 1'b0;
                exp_q.delete();
            end else begin
                e++;
                tk = (e % 2 == 0) && run;
                if (tk) n++;
            end
            exp_q.push_back(expect_at(e, n, tk));
        end
    end

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial forever begin
        @(negedge Clk);
        if (exp_q.size() != 0) begin
            exp_t ex;
            ex = exp_q.pop_front();
            chk("VGA_CLK",     16'(VGA_CLK),     16'(ex.ck));
            chk("DrawX",       16'(DrawX),       16'(ex.x));
            chk("DrawY",       16'(DrawY),       16'(ex.y));
            chk("VGA_HS",      16'(VGA_HS),      16'(ex.hs));
            chk("VGA_VS",      16'(VGA_VS),      16'(ex.vs));
            chk("VGA_BLANK_N", 16'(VGA_BLANK_N), 16'(ex.bn));
            chk("line_start",  16'(line_start),  16'(ex.ls));
            chk("frame_start", 16'(frame_start), 16'(ex.fs));
`ifdef VGA_FRAME_COUNT_EN
            chk("frame_count", frame_count,      ex.fc);
`endif
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_VGA_CLK"},     16'(VGA_CLK),     16'd0);
        chk({tag, "_DrawX"},       16'(DrawX),       16'd0);
        chk({tag, "_DrawY"},       16'(DrawY),       16'd0);
        chk({tag, "_VGA_HS"},      16'(VGA_HS),      16'd1);
        chk({tag, "_VGA_VS"},      16'(VGA_VS),      16'd1);
        chk({tag, "_VGA_BLANK_N"}, 16'(VGA_BLANK_N), 16'd0);
        chk({tag, "_line_start"},  16'(line_start),  16'd0);
        chk({tag, "_frame_start"}, 16'(frame_start), 16'd0);
`ifdef VGA_FRAME_COUNT_EN
        chk({tag, "_frame_count"}, frame_count,      16'd0);
`endif
    endtask

    // Wait (at negedges) until DrawX == x and, if y >= 0, DrawY == y.
    task automatic wait_xy(input int x, input int y, input int limit);
        int k;
        k = 0;
        while (!(int'(DrawX) == x && (y < 0 || int'(DrawY) == y)) && k < limit) begin
            @(negedge Clk);
            k++;
        end
        if (k >= limit) begin
            checks++;
            errors++;
            $display("FAIL wait_xy: DrawX=%0d DrawY=%0d never reached %0d,%0d", DrawX, DrawY, x, y);
        end
    endtask

    initial begin
        run     = 1'b1;
        Reset_n = 1'b0;
        repeat (5) @(posedge Clk);
        #1 check_reset_vals("rst_hold");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Random run gating across several frames.
        for (int i = 0; i < 9000; i++) begin
            @(negedge Clk);
            run = ($urandom_range(0, 15) != 0);
        end
        @(negedge Clk);
        run = 1'b1;

        // Mid-line stall of 10 Clk.
        wait_xy(20, -1, 4 * HT);
        run = 1'b0;
        repeat (10) @(negedge Clk);
        run = 1'b1;

        // Stall across the line-wrap tick.
        wait_xy(HT - 1, -1, 4 * HT);
        run = 1'b0;
        repeat (6) @(negedge Clk);
        run = 1'b1;

        // Stall across the frame-wrap tick.
        wait_xy(HT - 1, VT - 1, 4 * FT);
        run = 1'b0;
        repeat (5) @(negedge Clk);
        run = 1'b1;

        // Asynchronous reset mid-frame.
        wait_xy(30, 5, 4 * FT);
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1 check_reset_vals("rst_async");
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;

        // Three full frames with run held high.
        repeat (3 * 2 * FT + 100) @(negedge Clk);
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count_after_3", frame_count, 16'd3);
`endif
        chk("DrawY_after_3_frames", 16'(DrawY), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
